// File: rtl/fsm_iris_pkg.sv
// -----------------------------------------------------------------------------
// fsm_iris_pkg
// Shared definitions for the serializer front end and the downstream sequence
// detector.
//   ST_IDLE / ST_SHIFT : serializer state encoding
//   IRIS_WORD_W        : default word width, also used by the detector bench
// -----------------------------------------------------------------------------
package fsm_iris_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int IRIS_WORD_W = 8;

endpackage : fsm_iris_pkg

// File: rtl/fsm_bit_serializer.sv
// -----------------------------------------------------------------------------
// fsm_bit_serializer
// Parallel-to-serial front end. Accepted WIDTH-bit words pass through a
// one-entry holding register into a shifter, which emits one bit per enabled
// step on ser_bit (the detector's `in` input). A full holding register lets
// the next word chain onto the current one with no idle gap.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   load_data   word to serialize
//   load_valid  load_data valid this cycle
//   load_ready  holding register empty (registered, = !hold_full)
//   shift_en    step enable; shifter freezes while low
//   ser_bit     serial bit, IDLE_BIT when nothing is being shifted
//   ser_valid   high while ser_bit carries word data
//   frame_done  one-cycle pulse after the last bit of a word retires
// -----------------------------------------------------------------------------
module fsm_bit_serializer
    import fsm_iris_pkg::*;
#(
    parameter int WIDTH     = IRIS_WORD_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             frame_done
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic             state;
    logic             state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic accept;
    logic last_step;
    logic transfer;
    logic advance;
    logic cur_bit;

    // Step qualifiers shared by the next-state logic and the datapath.
    assign accept    = load_valid && !hold_full;
    assign last_step = (state == ST_SHIFT) && shift_en && (bit_cnt == LAST_CNT);
    assign advance   = (state == ST_SHIFT) && shift_en && (bit_cnt != LAST_CNT);
    // IDLE pickup ignores shift_en; the chained pickup rides the last step.
    assign transfer  = hold_full && ((state == ST_IDLE) || last_step);

    assign load_ready = !hold_full;
    assign cur_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: assigning a default first keeps every path covered, so no latch
    // is inferred for state_next.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (hold_full) state_next = ST_SHIFT;
            ST_SHIFT: if (last_step && !hold_full) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        ser_valid = (state == ST_SHIFT);
        ser_bit   = ser_valid ? cur_bit : IDLE_BIT;
    end

    // --------------------------------------------------- shifter / counter / done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            hold_full  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_step;

            if (transfer) begin
                shreg     <= hold;
                bit_cnt   <= '0;
                hold_full <= 1'b0;
            end else if (advance) begin
                shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            // Accept needs an empty hold and transfer needs a full one, so the
            // two never touch hold_full on the same edge.
            if (accept) begin
                hold_full <= 1'b1;
            end
        end
    end

    // NOTE: the holding data register has no reset; hold_full alone says
    // whether its contents mean anything, so clearing the data buys nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= load_data;
        end
    end

endmodule : fsm_bit_serializer

// File: tb/tb_fsm_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_fsm_bit_serializer
// Directed bench for fsm_bit_serializer. One instance sends MSB first, a
// second instance sends LSB first. Outputs are sampled 1 time unit after the
// rising edge; inputs are driven at the same point so they settle well before
// the next edge.
// -----------------------------------------------------------------------------
module tb_fsm_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         shift_en;
    logic         ser_bit;
    logic         ser_valid;
    logic         frame_done;

    logic         lsb_valid;
    logic         lsb_ready;
    logic         lsb_bit;
    logic         lsb_ser_valid;
    logic         lsb_done;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .frame_done (frame_done)
    );

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (lsb_valid),
        .load_ready (lsb_ready),
        .shift_en   (shift_en),
        .ser_bit    (lsb_bit),
        .ser_valid  (lsb_ser_valid),
        .frame_done (lsb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word on the MSB-first instance and return just after the edge
    // that accepted it.
    task automatic send(input logic [W-1:0] word);
        bit done = 1'b0;
        load_data  = word;
        load_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            if (load_ready) done = 1'b1;
            tick();
        end
        load_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    initial begin
        logic [W-1:0]  word;
        logic [15:0]   stream;

        reset      = 1'b0;
        load_data  = '0;
        load_valid = 1'b0;
        lsb_valid  = 1'b0;
        shift_en   = 1'b1;
        #2;

        // ---- reset held for 5 cycles
        for (int c = 0; c < 5; c++) begin
            check("rst_ser_bit",    32'(ser_bit),    32'd0);
            check("rst_ser_valid",  32'(ser_valid),  32'd0);
            check("rst_load_ready", 32'(load_ready), 32'd1);
            check("rst_frame_done", 32'(frame_done), 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        check("idle_ser_valid", 32'(ser_valid), 32'd0);

        // ---- single word 0xA5, MSB first
        word = 8'hA5;
        send(word);
        check("a5_latency_valid", 32'(ser_valid),  32'd0);
        check("a5_hold_ready",    32'(load_ready), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("a5_bit",   32'(ser_bit),    32'(word[7-i]));
            check("a5_valid", 32'(ser_valid),  32'd1);
            check("a5_done",  32'(frame_done), 32'd0);
            tick();
        end
        check("a5_done_pulse", 32'(frame_done), 32'd1);
        check("a5_end_valid",  32'(ser_valid),  32'd0);
        check("a5_end_bit",    32'(ser_bit),    32'd0);
        tick();
        check("a5_done_once",  32'(frame_done), 32'd0);

        // ---- back-to-back 0xA5 then 0x3C
        stream = 16'hA53C;
        send(8'hA5);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("chain_bit",   32'(ser_bit),    32'(stream[15-i]));
            check("chain_valid", 32'(ser_valid),  32'd1);
            check("chain_done",  32'(frame_done), 32'(i == 8));
            if (i == 0) begin
                check("chain_ready", 32'(load_ready), 32'd1);
                load_data  = 8'h3C;
                load_valid = 1'b1;
            end
            if (i == 1) load_valid = 1'b0;
            tick();
        end
        check("chain_done_end", 32'(frame_done), 32'd1);
        check("chain_end_valid", 32'(ser_valid), 32'd0);
        tick();
        check("chain_done_clr", 32'(frame_done), 32'd0);

        // ---- LSB-first instance with 0x01
        word      = 8'h01;
        load_data = word;
        check("lsb_ready0", 32'(lsb_ready), 32'd1);
        lsb_valid = 1'b1;
        tick();
        lsb_valid = 1'b0;
        check("lsb_hold_ready", 32'(lsb_ready), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("lsb_bit",   32'(lsb_bit),       32'(word[i]));
            check("lsb_valid", 32'(lsb_ser_valid), 32'd1);
            tick();
        end
        check("lsb_done",      32'(lsb_done),      32'd1);
        check("lsb_end_valid", 32'(lsb_ser_valid), 32'd0);

        // ---- 0xF0 with shift_en alternating: each bit held 2 cycles
        word = 8'hF0;
        send(word);
        tick();
        for (int c = 0; c < 16; c++) begin
            check("slow_bit",   32'(ser_bit),    32'(word[7 - c/2]));
            check("slow_valid", 32'(ser_valid),  32'd1);
            check("slow_done",  32'(frame_done), 32'd0);
            shift_en = (c % 2 == 1);
            tick();
        end
        check("slow_done_end",  32'(frame_done), 32'd1);
        check("slow_end_valid", 32'(ser_valid),  32'd0);
        shift_en = 1'b1;
        tick();

        // ---- reset mid-word (bit 4 of 0xFF) with the hold full
        send(8'hFF);
        tick();
        load_data  = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_valid_pre", 32'(ser_valid),  32'd1);
        check("mid_bit_pre",   32'(ser_bit),    32'd1);
        check("mid_hold_full", 32'(load_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ser_valid),  32'd0);
        check("mid_rst_ready", 32'(load_ready), 32'd1);
        check("mid_rst_bit",   32'(ser_bit),    32'd0);
        check("mid_rst_done",  32'(frame_done), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("post_rst_valid", 32'(ser_valid),  32'd0);
            check("post_rst_done",  32'(frame_done), 32'd0);
            check("post_rst_ready", 32'(load_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fsm_bit_serializer
